score_tracker: RTL

- Downstream consumer of all arrow dropper stages.
- Collects each dropper's hit level (scoreNN) and miss level and tracks game time.
- Produces the running score, the current and best combo, and the end-of-game flag for the HUD/text renderer.
- Clocked on frame_clk, one update per video frame, alongside the droppers.

---
 rtl/rhythm_pkg.sv | 14 +
 rtl/edge_popcount.sv | 24 ++
 rtl/score_tracker.sv | 103 ++++++++++
 3 files changed

// File: rtl/rhythm_pkg.sv
// Shared types and constants for the rhythm-game score path.
package rhythm_pkg;
  typedef enum logic [1:0] {IDLE, PLAY, DONE} score_state_t;

  localparam logic [7:0] KEY_START = 8'h2c;
  localparam logic [7:0] KEY_RESET = 8'h01;
  localparam int COMBO_BONUS_THRESH = 10;
  localparam int COMBO_MAX          = 255;

  function automatic logic key_hit(input logic [7:0] a, input logic [7:0] b,
                                   input logic [7:0] k);
    return (a == k) || (b == k);
  endfunction
endpackage

// File: rtl/edge_popcount.sv
// Registers a level vector and counts bits that rose since the last frame.
module edge_popcount #(
  parameter int N = 32,
  localparam int CW = $clog2(N + 1)
) (
  input  logic          frame_clk,
  input  logic          Reset,
  input  logic [N-1:0]  vec,
  output logic [CW-1:0] cnt
);
  logic [N-1:0] prev;
  logic [N-1:0] rise;

  always_ff @(posedge frame_clk or negedge Reset)
    if (!Reset) prev <= '0;
    else        prev <= vec;

  assign rise = vec & ~prev;

  always_comb begin
    cnt = '0;
    for (int i = 0; i < N; i++) cnt = cnt + CW'(rise[i]);
  end
endmodule

// File: rtl/score_tracker.sv
// Score / combo / game-timer tracker fed by the arrow droppers.
// Optional COMBO_BONUS_EN: hits score double while the combo is at or above threshold.
module score_tracker
  import rhythm_pkg::*;
#(
  parameter int NUM_DROPS   = 32,
  parameter int SCORE_W     = 16,
  parameter int HIT_POINTS  = 1,
  parameter int GAME_FRAMES = 4096
) (
  input  logic                 frame_clk,
  input  logic                 Reset,
  input  logic [7:0]           keycode,
  input  logic [7:0]           keycode_second,
  input  logic [NUM_DROPS-1:0] score_vec,
  input  logic [NUM_DROPS-1:0] miss_vec,
  output logic [SCORE_W-1:0]   score,
  output logic [7:0]           combo,
  output logic [7:0]           max_combo,
  output logic                 hit_pulse,
  output logic                 game_over,
  output logic                 playing
);
  localparam int CW = $clog2(NUM_DROPS + 1);
  localparam int FW = (GAME_FRAMES > 2) ? $clog2(GAME_FRAMES) : 1;
  localparam int AW = SCORE_W + 7;

  score_state_t  state;
  logic [FW-1:0] frame_cnt;
  logic [CW-1:0] nh, nm;
  logic          start_key, rst_key;
  logic [AW-1:0] pts, sum;
  logic [SCORE_W-1:0] score_nxt;
  logic [8:0]    combo_sum;
  logic [7:0]    combo_nxt, max_nxt;

  edge_popcount #(.N(NUM_DROPS)) u_hit  (.frame_clk(frame_clk), .Reset(Reset), .vec(score_vec), .cnt(nh));
  edge_popcount #(.N(NUM_DROPS)) u_miss (.frame_clk(frame_clk), .Reset(Reset), .vec(miss_vec),  .cnt(nm));

  assign start_key = key_hit(keycode, keycode_second, KEY_START);
  assign rst_key   = key_hit(keycode, keycode_second, KEY_RESET);

  always_comb begin
`ifdef COMBO_BONUS_EN
    pts = (combo >= 8'(COMBO_BONUS_THRESH)) ? AW'(2 * HIT_POINTS) : AW'(HIT_POINTS);
`else
    pts = AW'(HIT_POINTS);
`endif
    sum       = AW'(score) + AW'(nh) * pts;
    score_nxt = (sum > AW'({SCORE_W{1'b1}})) ? '1 : sum[SCORE_W-1:0];
    combo_sum = 9'(combo) + 9'(nh);
    // a miss in the frame wipes the combo even if hits landed alongside it
    if (nm != '0)                      combo_nxt = '0;
    else if (combo_sum > 9'(COMBO_MAX)) combo_nxt = 8'(COMBO_MAX);
    else                               combo_nxt = combo_sum[7:0];
    max_nxt = (combo_nxt > max_combo) ? combo_nxt : max_combo;
  end

  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      score     <= '0;
      combo     <= '0;
      max_combo <= '0;
      hit_pulse <= 1'b0;
      game_over <= 1'b0;
      playing   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      hit_pulse <= 1'b0;
      case (state)
        IDLE: if (start_key && !rst_key) begin
          state     <= PLAY;
          playing   <= 1'b1;
          score     <= '0;
          combo     <= '0;
          max_combo <= '0;
          frame_cnt <= '0;
        end
        PLAY: if (rst_key) begin
          state   <= IDLE;
          playing <= 1'b0;
        end else begin
          score     <= score_nxt;
          combo     <= combo_nxt;
          max_combo <= max_nxt;
          hit_pulse <= (nh != '0);
          frame_cnt <= frame_cnt + 1'b1;
          if (frame_cnt == FW'(GAME_FRAMES - 1)) begin
            state     <= DONE;
            playing   <= 1'b0;
            game_over <= 1'b1;
          end
        end
        DONE: if (rst_key) begin
          state     <= IDLE;
          game_over <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
